// File: rtl/power_accum.sv
// Per-column, four-lane power integrator: accumulates up to two columns per beat over a
// configurable number of frames, then streams every column out with valid/ready flow control.
module power_accum #(
  parameter int IN_WIDTH  = 52,
  parameter int ACC_WIDTH = 60,
  parameter int NUM_COLS  = 2048,
  parameter int FRAMES_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FRAMES_W-1:0]    cfg_frames,
  input  logic                   in_valid,
  input  logic [4*IN_WIDTH-1:0]  in_col1,
  input  logic [4*IN_WIDTH-1:0]  in_col2,
  input  logic [10:0]            in_idx1,
  input  logic [10:0]            in_idx2,
  input  logic                   in_frame_last,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [10:0]            out_idx,
  output logic [4*ACC_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   done,
  output logic                   sat_flag,
  output logic                   drop_flag
);

  localparam int AW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int SW = ACC_WIDTH + 2;
  localparam logic [11:0]   COLS_LIM = 12'(NUM_COLS);
  localparam logic [AW-1:0] LAST_COL = AW'(NUM_COLS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  typedef logic [3:0][ACC_WIDTH-1:0] entry_t;

  state_t              state, state_nxt;
  entry_t              acc_mem [NUM_COLS];
  logic [NUM_COLS-1:0] bitmap;
  logic [FRAMES_W-1:0] frames_q, frame_cnt, frame_inc;
  logic [AW-1:0]       rd_ptr;

  logic                use2, ok1, ok2, same, beat_en, wr1, wr2, sat1, sat2;
  logic [AW-1:0]       a1, a2;
  logic [3:0][SW-1:0]  sum1, sum2;
  entry_t              new1, new2;

  assign frame_inc = frame_cnt + 1'b1;

  // Read-modify-write for both columns of the beat; a shared index folds col2 into col1's sum.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    use2    = in_idx1 > 11'd1;
    ok1     = {1'b0, in_idx1} < COLS_LIM;
    ok2     = use2 && ({1'b0, in_idx2} < COLS_LIM);
    a1      = in_idx1[AW-1:0];
    a2      = in_idx2[AW-1:0];
    same    = ok1 && ok2 && (a1 == a2);
    beat_en = (state == ACCUM) && in_valid;
    wr1     = beat_en && ok1;
    wr2     = beat_en && ok2 && !same;
    sat1    = 1'b0;
    sat2    = 1'b0;
    sum1    = '0;
    sum2    = '0;
    new1    = '0;
    new2    = '0;
    for (int l = 0; l < 4; l++) begin
      sum1[l] = (bitmap[a1] ? SW'(acc_mem[a1][l]) : '0)
              + SW'(in_col1[l*IN_WIDTH +: IN_WIDTH])
              + (same ? SW'(in_col2[l*IN_WIDTH +: IN_WIDTH]) : '0);
      sum2[l] = (bitmap[a2] ? SW'(acc_mem[a2][l]) : '0)
              + SW'(in_col2[l*IN_WIDTH +: IN_WIDTH]);
      sat1 = sat1 | (|sum1[l][SW-1:ACC_WIDTH]);
      sat2 = sat2 | (|sum2[l][SW-1:ACC_WIDTH]);
      new1[l] = (|sum1[l][SW-1:ACC_WIDTH]) ? '1 : sum1[l][ACC_WIDTH-1:0];
      new2[l] = (|sum2[l][SW-1:ACC_WIDTH]) ? '1 : sum2[l][ACC_WIDTH-1:0];
    end
  end

  // NOTE: the accumulator array is deliberately not reset; the bitmap alone marks valid entries.
  always_ff @(posedge clk) begin
    if (wr1) acc_mem[a1] <= new1;
    if (wr2) acc_mem[a2] <= new2;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (in_valid && in_frame_last && (frame_inc == frames_q)) state_nxt = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      frames_q  <= FRAMES_W'(1);
      frame_cnt <= '0;
      rd_ptr    <= '0;
      bitmap    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= 1'b0;

      if (in_valid && (state != ACCUM)) drop_flag <= 1'b1;

      // A new run clears the sticky flags last, so its own edge starts them clean.
      if ((state == IDLE) && start) begin
        frames_q  <= (cfg_frames == '0) ? FRAMES_W'(1) : cfg_frames;
        frame_cnt <= '0;
        bitmap    <= '0;
        sat_flag  <= 1'b0;
        drop_flag <= 1'b0;
      end

      if (beat_en) begin
        if (wr1) bitmap[a1] <= 1'b1;
        if (wr2) bitmap[a2] <= 1'b1;
        if ((wr1 && sat1) || (wr2 && sat2)) sat_flag <= 1'b1;
        if (!ok1 || (use2 && !ok2)) drop_flag <= 1'b1;
        if (in_frame_last) frame_cnt <= frame_inc;
      end

      if ((state == ACCUM) && (state_nxt == DRAIN)) rd_ptr <= '0;

      if (state == DRAIN) begin
        if (out_valid && out_ready && out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b1;
        end else if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_idx   <= 11'(rd_ptr);
          out_data  <= bitmap[rd_ptr] ? acc_mem[rd_ptr] : '0;
          out_last  <= (rd_ptr == LAST_COL);
          rd_ptr    <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_power_accum.sv
// Directed bench for power_accum: an 8-column 60-bit instance plus a 52-bit twin that
// shares all inputs and exposes saturation.
module tb_power_accum;

  localparam int IW   = 52;
  localparam int AW_M = 60;
  localparam int AW_S = 52;
  localparam int NC   = 8;
  localparam int FW   = 8;
  localparam logic [IW-1:0] F52 = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, in_valid, in_frame_last, out_ready;
  logic [FW-1:0]     cfg_frames;
  logic [4*IW-1:0]   in_col1, in_col2;
  logic [10:0]       in_idx1, in_idx2;
  logic              busy, out_valid, out_last, done, sat_flag, drop_flag;
  logic [10:0]       out_idx;
  logic [4*AW_M-1:0] out_data;
  logic              s_busy, s_out_valid, s_out_last, s_done, s_sat_flag, s_drop_flag;
  logic [10:0]       s_out_idx;
  logic [4*AW_S-1:0] s_out_data;

  power_accum #(.IN_WIDTH(IW), .ACC_WIDTH(AW_M), .NUM_COLS(NC), .FRAMES_W(FW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_frames(cfg_frames), .in_valid(in_valid),
    .in_col1(in_col1), .in_col2(in_col2), .in_idx1(in_idx1), .in_idx2(in_idx2),
    .in_frame_last(in_frame_last), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last), .done(done),
    .sat_flag(sat_flag), .drop_flag(drop_flag));

  power_accum #(.IN_WIDTH(IW), .ACC_WIDTH(AW_S), .NUM_COLS(NC), .FRAMES_W(FW)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_frames(cfg_frames), .in_valid(in_valid),
    .in_col1(in_col1), .in_col2(in_col2), .in_idx1(in_idx1), .in_idx2(in_idx2),
    .in_frame_last(in_frame_last), .busy(s_busy), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_idx(s_out_idx), .out_data(s_out_data), .out_last(s_out_last), .done(s_done),
    .sat_flag(s_sat_flag), .drop_flag(s_drop_flag));

  typedef struct {
    logic [10:0]   i1;
    logic [10:0]   i2;
    logic [IW-1:0] v1;
    logic [IW-1:0] v2;
    bit            last;
  } beat_t;

  int total = 0;
  int bad   = 0;
  logic [AW_M-1:0] exp_mem [NC][4];
  logic [AW_S-1:0] s_exp   [NC][4];
  bit check_sat = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [4*IW-1:0] col(input logic [IW-1:0] v, input logic [IW-1:0] step);
    logic [4*IW-1:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[l*IW +: IW] = v + IW'(l) * step;
    return r;
  endfunction

  task automatic clear_exp();
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < 4; l++) begin
        exp_mem[c[2:0]][l[1:0]] = '0;
        s_exp[c[2:0]][l[1:0]]   = '0;
      end
  endtask

  task automatic set_exp(input logic [2:0] idx, input logic [AW_M-1:0] v, input logic [AW_M-1:0] step);
    for (int l = 0; l < 4; l++) exp_mem[idx][l[1:0]] = v + AW_M'(l) * step;
  endtask

  task automatic beat(input logic [10:0] i1, input logic [10:0] i2,
                      input logic [4*IW-1:0] c1, input logic [4*IW-1:0] c2, input bit last);
    @(negedge clk);
    in_valid = 1'b1; in_idx1 = i1; in_idx2 = i2;
    in_col1 = c1; in_col2 = c2; in_frame_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_frame_last = 1'b0;
  endtask

  task automatic start_run(input int frames);
    @(negedge clk);
    start = 1'b1; cfg_frames = FW'(frames);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy after start", 256'(busy), 256'(1));
  endtask

  // pat[k] is out_ready for drain cycle k mod 4; every accepted beat is compared in order.
  task automatic drain(input string name, input logic [3:0] pat);
    int got, cyc;
    logic held_ok;
    logic [10:0] h_idx;
    logic [4*AW_M-1:0] h_data, e;
    logic [4*AW_S-1:0] se;
    got = 0; cyc = 0; held_ok = 1'b0; h_idx = '0; h_data = '0;
    while (got < NC && cyc < 200) begin
      out_ready = pat[2'(cyc)];
      if (out_valid) begin
        if (held_ok) begin
          check({name, " hold idx"}, 256'(out_idx), 256'(h_idx));
          check({name, " hold data"}, 256'(out_data), 256'(h_data));
        end
        if (out_ready) begin
          for (int l = 0; l < 4; l++) begin
            e[l*AW_M +: AW_M]  = exp_mem[got[2:0]][l[1:0]];
            se[l*AW_S +: AW_S] = s_exp[got[2:0]][l[1:0]];
          end
          check({name, " idx"}, 256'(out_idx), 256'(got));
          check({name, " data"}, 256'(out_data), 256'(e));
          check({name, " last"}, 256'(out_last), 256'(got == NC - 1));
          if (check_sat) check({name, " sat data"}, 256'(s_out_data), 256'(se));
          got++;
          held_ok = 1'b0;
        end else begin
          held_ok = 1'b1; h_idx = out_idx; h_data = out_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " beat count"}, 256'(got), 256'(NC));
    check({name, " done pulse"}, 256'(done), 256'(1));
    check({name, " valid drop"}, 256'(out_valid), 256'(0));
    check({name, " idle busy"}, 256'(busy), 256'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " done width"}, 256'(done), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t s1 [5];
    int n;

    rst_n = 1'b0; start = 1'b0; cfg_frames = '0; in_valid = 1'b0; in_frame_last = 1'b0;
    in_col1 = '0; in_col2 = '0; in_idx1 = '0; in_idx2 = '0; out_ready = 1'b1;

    // Frame pattern: idx2 of the first two beats must be ignored (idx1 is 0 or 1).
    s1[0] = '{11'd0, 11'd5, 52'd10, 52'd10, 1'b0};
    s1[1] = '{11'd1, 11'd2, 52'd10, 52'd10, 1'b0};
    s1[2] = '{11'd2, 11'd5, 52'd10, 52'd10, 1'b0};
    s1[3] = '{11'd3, 11'd4, 52'd10, 52'd10, 1'b0};
    s1[4] = '{11'd6, 11'd7, 52'd10, 52'd10, 1'b1};

    #12;
    check("rst busy", 256'(busy), 256'(0));
    check("rst out_valid", 256'(out_valid), 256'(0));
    check("rst out_last", 256'(out_last), 256'(0));
    check("rst done", 256'(done), 256'(0));
    check("rst sat", 256'(sat_flag), 256'(0));
    check("rst drop", 256'(drop_flag), 256'(0));
    check("rst out_idx", 256'(out_idx), 256'(0));
    check("rst out_data", 256'(out_data), 256'(0));
    @(negedge clk); rst_n = 1'b1;

    // Two frames of 10 on every column; a start pulse mid-run must be ignored.
    clear_exp();
    for (int c = 0; c < NC; c++) set_exp(c[2:0], 60'd20, 60'd0);
    start_run(2);
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 5; b++) begin
        if (f == 1 && b == 0) begin start = 1'b1; cfg_frames = 8'd5; end
        beat(s1[b].i1, s1[b].i2, col(s1[b].v1, '0), col(s1[b].v2, '0), s1[b].last);
        start = 1'b0;
      end
      if (f == 0) begin
        check("s1 no early drain", 256'(out_valid), 256'(0));
        check("s1 busy between frames", 256'(busy), 256'(1));
      end
    end
    check("s1 latency cycle1", 256'(out_valid), 256'(0));
    @(posedge clk); #1;
    check("s1 latency cycle2", 256'(out_valid), 256'(1));
    drain("s1", 4'b1111);
    check("s1 sat", 256'(sat_flag), 256'(0));
    check("s1 drop", 256'(drop_flag), 256'(0));

    // idx1=0 disables col2; drain with ready pattern 1,0,0,1.
    clear_exp();
    set_exp(3'd0, 60'd7, 60'd1);
    start_run(1);
    beat(11'd0, 11'd5, col(52'd7, 52'd1), col(52'd99, '0), 1'b1);
    drain("s2", 4'b1001);
    check("s2 drop", 256'(drop_flag), 256'(0));

    // All-ones lanes: same-index fold on col 2, plain accumulate on col 6, idx2=9 dropped.
    clear_exp();
    set_exp(3'd2, 60'h20_0000_0000_0008, 60'd0);
    set_exp(3'd6, 60'h1F_FFFF_FFFF_FFFE, 60'd0);
    for (int l = 0; l < 4; l++) begin
      s_exp[2][l[1:0]] = F52;
      s_exp[6][l[1:0]] = F52;
    end
    check_sat = 1'b1;
    start_run(2);
    for (int f = 0; f < 2; f++) begin
      beat(11'd2, 11'd2, col(F52, '0), col(52'd5, '0), 1'b0);
      beat(11'd6, 11'd9, col(F52, '0), col(52'd1, '0), 1'b1);
    end
    drain("s3", 4'b1111);
    check_sat = 1'b0;
    check("s3 wide sat clear", 256'(sat_flag), 256'(0));
    check("s3 narrow sat set", 256'(s_sat_flag), 256'(1));
    check("s3 drop", 256'(drop_flag), 256'(1));
    check("s3 narrow drop", 256'(s_drop_flag), 256'(1));

    // Reset mid-drain, then a cfg_frames=0 run sees only its own writes.
    start_run(1);
    beat(11'd2, 11'd5, col(52'd1, 52'd1), col(52'd2, 52'd1), 1'b1);
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_idx == 11'd3) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("s5 reached idx3", 256'(out_valid && out_idx == 11'd3), 256'(1));
    rst_n = 1'b0;
    #1;
    check("s5 rst out_valid", 256'(out_valid), 256'(0));
    check("s5 rst busy", 256'(busy), 256'(0));
    check("s5 rst out_idx", 256'(out_idx), 256'(0));
    check("s5 rst out_data", 256'(out_data), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s5 no resume", 256'(out_valid), 256'(0));
    clear_exp();
    set_exp(3'd7, 60'd100, 60'd2);
    set_exp(3'd1, 60'd50, 60'd0);
    start_run(0);
    beat(11'd7, 11'd1, col(52'd100, 52'd2), col(52'd50, '0), 1'b1);
    drain("s5", 4'b1111);

    // Drops: a beat in IDLE, a lone frame_last, and idx1 out of range.
    beat(11'd3, 11'd5, col(52'd77, '0), col(52'd77, '0), 1'b0);
    check("s6 idle drop", 256'(drop_flag), 256'(1));
    start_run(1);
    check("s6 start clears drop", 256'(drop_flag), 256'(0));
    @(negedge clk); in_frame_last = 1'b1;
    @(posedge clk); #1; in_frame_last = 1'b0;
    @(posedge clk); #1;
    check("s6 lone frame_last", 256'(out_valid), 256'(0));
    clear_exp();
    set_exp(3'd3, 60'd6, 60'd0);
    set_exp(3'd1, 60'd3, 60'd0);
    beat(11'd9, 11'd3, col(52'd5, '0), col(52'd6, '0), 1'b0);
    check("s6 range drop", 256'(drop_flag), 256'(1));
    beat(11'd1, 11'd6, col(52'd3, '0), col(52'd88, '0), 1'b1);
    drain("s6", 4'b1111);
    check("s6 drop sticky", 256'(drop_flag), 256'(1));
    check("s6 sat", 256'(sat_flag), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/power_accum.md
POWER_ACCUM -- requirements
Module: power_accum

Interface
REQ-001 Parameters SHALL be:
- IN_WIDTH, default 52, width of one power-lane sample.
- ACC_WIDTH, default 60, width of one accumulator lane.
- NUM_COLS, default 2048, number of column entries (at most 2048).
- FRAMES_W, default 8, width of the frame-count configuration.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin integration run; sampled in IDLE only.
- cfg_frames  in  FRAMES_W  frames to integrate; 0 is treated as 1.
- in_valid  in  1  input beat strobe from the power-square stage.
- in_col1  in  4xIN_WIDTH  four lane powers for column in_idx1.
- in_col2  in  4xIN_WIDTH  four lane powers for column in_idx2.
- in_idx1  in  11  first column index.
- in_idx2  in  11  second column index.
- in_frame_last  in  1  qualifies the in_valid beat as the last beat of a frame.
- busy  out  1  high when not IDLE.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  downstream accept.
- out_idx  out  11  column index of the drain beat.
- out_data  out  4xACC_WIDTH  accumulated lane sums.
- out_last  out  1  final drain beat.
- done  out  1  one-cycle pulse after the last beat is accepted.
- sat_flag  out  1  sticky; set when any accumulation saturated.
- drop_flag  out  1  sticky; set when an input beat was discarded.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCUM and DRAIN.
REQ-004 In IDLE, start=1 SHALL do all of the following on one edge:
- latch max(cfg_frames,1);
- clear frame_cnt;
- clear the per-column written bitmap (NUM_COLS bits);
- clear sat_flag and drop_flag;
- move to ACCUM.
REQ-005 start outside IDLE SHALL be ignored.
REQ-006 In ACCUM, each in_valid beat SHALL update entry in_idx1 with in_col1, lane-wise.
REQ-007 The same beat SHALL update entry in_idx2 with in_col2, except when in_idx1 is 0 or 1; in that case in_col2 and in_idx2 are ignored.
REQ-008 Update rule per lane:
- new = (bitmap[idx] ? acc[idx] : 0) + zero-extended input;
- set bitmap[idx];
- if the sum exceeds 2^ACC_WIDTH-1, clamp it to all-ones and set sat_flag.
REQ-009 If in_idx1==in_idx2 and col2 is used, the entry SHALL receive acc+in_col1+in_col2, saturated as in REQ-008.
REQ-010 If an index is >= NUM_COLS, that column's write SHALL be discarded and drop_flag set; the other column still updates.
REQ-011 An in_valid beat with in_frame_last=1 SHALL increment frame_cnt after its write.
REQ-012 When the incremented frame_cnt equals the latched frame count, the FSM SHALL enter DRAIN on the same edge.
REQ-013 in_valid in IDLE or DRAIN SHALL be discarded and SHALL set drop_flag; in_frame_last without in_valid SHALL be ignored.
REQ-014 On DRAIN entry:
- rd_ptr SHALL be 0;
- out_valid SHALL rise 1 cycle later;
- out_idx and out_data SHALL be registered from rd_ptr.
REQ-015 out_data SHALL be 0 for entries whose bitmap bit is clear.
REQ-016 While out_valid=1 and out_ready=0, out_idx, out_data and out_last SHALL hold stable.
REQ-017 On each accept (out_valid&&out_ready) the next entry SHALL be presented on the following edge, giving a sustained rate of 1 beat/cycle.
REQ-018 out_last SHALL be 1 exactly on the beat with out_idx=NUM_COLS-1.
REQ-019 Acceptance of the last beat SHALL:
- deassert out_valid;
- pulse done for 1 cycle;
- return the FSM to IDLE.
REQ-020 Latency from the final in_frame_last beat to the first out_valid SHALL be 2 cycles.
REQ-021 busy SHALL equal (state!=IDLE), registered.

Reset
REQ-022 rst_n=0 SHALL asynchronously force the following, including mid-ACCUM or mid-DRAIN, with no drain resumption:
- FSM to IDLE;
- frame_cnt, rd_ptr, bitmap, busy, out_valid, out_last, done, sat_flag, drop_flag to 0;
- out_idx and out_data to 0.
REQ-023 Accumulator array contents SHALL NOT be reset; the bitmap alone defines validity.

Verification
REQ-024 Scenarios (NUM_COLS=8, ACC_WIDTH=60, IN_WIDTH=52):
- cfg_frames=2; per frame, beats (idx1,idx2)=(0,x),(1,x),(2,5),(3,4),(6,7), all lanes=10, last beat frame_last -> drain idx0..7 each lane=20, out_last on idx7, done pulse, sat_flag=drop_flag=0.
- cfg_frames=1; beat idx1=0, in_col2=99 at idx2=5 -> entry0=in_col1 value, entry5 drains 0.
- Two frames of lane value 2^52-1 at ACC_WIDTH=52 build -> lanes saturate to all-ones, sat_flag=1.
- out_ready toggled 1,0,0,1 during drain -> out_idx/out_data held while stalled, 8 beats total, no duplicates or skips.
- rst_n pulsed mid-DRAIN at idx3 -> out_valid=0 and busy=0 immediately; new start with cfg_frames=0 runs 1 frame and drains correct values.
- in_valid while IDLE, and idx1=9 in ACCUM -> drop_flag=1, no array change for those writes.
